// File: rtl/erx_pkg.sv
// Shared widths and packet layout for the eLink RX transaction buffer.
package erx_pkg;

    localparam int EMESH_DW = 32;
    localparam int EMESH_AW = 32;
    localparam int DM_W     = 2;
    localparam int CM_W     = 4;
    localparam int RX_PKT_W = 102;

    // Packet layout, LSB first: data, srcaddr, dstaddr, ctrlmode, datamode
    localparam int PKT_DATA_LSB = 0;
    localparam int PKT_SRC_LSB  = 32;
    localparam int PKT_DST_LSB  = 64;
    localparam int PKT_CM_LSB   = 96;
    localparam int PKT_DM_LSB   = 100;

    function automatic logic [RX_PKT_W-1:0] pack_rx_pkt(
        input logic [DM_W-1:0]     datamode,
        input logic [CM_W-1:0]     ctrlmode,
        input logic [EMESH_AW-1:0] dstaddr,
        input logic [EMESH_AW-1:0] srcaddr,
        input logic [EMESH_DW-1:0] data
    );
        logic [RX_PKT_W-1:0] p;
        p = '0;
        p[PKT_DATA_LSB +: EMESH_DW] = data;
        p[PKT_SRC_LSB  +: EMESH_AW] = srcaddr;
        p[PKT_DST_LSB  +: EMESH_AW] = dstaddr;
        p[PKT_CM_LSB   +: CM_W]     = ctrlmode;
        p[PKT_DM_LSB   +: DM_W]     = datamode;
        return p;
    endfunction

endpackage

// File: rtl/erx_txn_buffer_if.sv
// Decoder-side capture bus plus the two consumer-side valid/ready queues.
interface erx_txn_buffer_if;
    import erx_pkg::*;

    logic                in_access;
    logic                in_write;
    logic [DM_W-1:0]     in_datamode;
    logic [CM_W-1:0]     in_ctrlmode;
    logic [EMESH_AW-1:0] in_dstaddr;
    logic [EMESH_AW-1:0] in_srcaddr;
    logic [EMESH_DW-1:0] in_data;

    logic                emesh_rx_wr_wait;
    logic                emesh_rx_rd_wait;

    logic                wr_valid;
    logic                wr_ready;
    logic [RX_PKT_W-1:0] wr_packet;
    logic                rd_valid;
    logic                rd_ready;
    logic [RX_PKT_W-1:0] rd_packet;

    logic                wr_overflow;
    logic                rd_overflow;

    // Buffer side
    modport slave (
        input  in_access, in_write, in_datamode, in_ctrlmode,
               in_dstaddr, in_srcaddr, in_data, wr_ready, rd_ready,
        output emesh_rx_wr_wait, emesh_rx_rd_wait, wr_valid, wr_packet,
               rd_valid, rd_packet, wr_overflow, rd_overflow
    );

    // Decoder + consumer side
    modport master (
        output in_access, in_write, in_datamode, in_ctrlmode,
               in_dstaddr, in_srcaddr, in_data, wr_ready, rd_ready,
        input  emesh_rx_wr_wait, emesh_rx_rd_wait, wr_valid, wr_packet,
               rd_valid, rd_packet, wr_overflow, rd_overflow
    );

endinterface

// File: rtl/erx_txn_fifo.sv
// One show-ahead transaction queue: count-based full/empty, registered
// threshold wait and a sticky overflow flag for pushes dropped while full.
module erx_txn_fifo
    import erx_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int WAIT_THRESH = 10
) (
    input  logic                rx_lclk_div4,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [RX_PKT_W-1:0] push_pkt,
    output logic                head_valid,
    output logic [RX_PKT_W-1:0] head_pkt,
    output logic                fifo_wait,
    output logic                overflow
);

    localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_CNT = (AW+1)'(WAIT_THRESH);

    logic [RX_PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [AW:0]         count_next;
    logic                full;
    logic                empty;
    logic                pop_ok;
    logic                push_ok;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    // A pop on an empty queue is meaningless (valid=0), so it is masked here.
    assign pop_ok = pop & ~empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push_ok = push & (~full | pop_ok);

    // Occupancy after this edge; the wait flag is derived from it so it moves with count.
    always_comb begin
        count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    // Pointers, count, wait and sticky overflow.
    always_ff @(posedge rx_lclk_div4 or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_wait <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            fifo_wait <= (count_next >= THRESH_CNT);
            if (push & ~push_ok) overflow <= 1'b1;
        end
    end

    // Storage is deliberately not reset; valid gating hides stale contents.
    always_ff @(posedge rx_lclk_div4) begin
        if (push_ok) mem[wr_ptr] <= push_pkt;
    end

    assign head_valid = ~empty;
    assign head_pkt   = mem[rd_ptr];

endmodule

// File: rtl/erx_txn_buffer.sv
// Steers decoded eMesh transactions into independent write and read queues.
module erx_txn_buffer
    import erx_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int WAIT_THRESH = 10
) (
    input  logic          rx_lclk_div4,
    input  logic          reset,
    erx_txn_buffer_if.slave bus
);

    logic [RX_PKT_W-1:0] in_pkt;
    logic                wr_push;
    logic                rd_push;

    assign in_pkt  = pack_rx_pkt(bus.in_datamode, bus.in_ctrlmode, bus.in_dstaddr,
                                 bus.in_srcaddr, bus.in_data);
    assign wr_push = bus.in_access &  bus.in_write;
    assign rd_push = bus.in_access & ~bus.in_write;

    erx_txn_fifo #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .WAIT_THRESH(WAIT_THRESH)
    ) u_wr_fifo (
        .rx_lclk_div4(rx_lclk_div4),
        .reset       (reset),
        .push        (wr_push),
        .pop         (bus.wr_ready),
        .push_pkt    (in_pkt),
        .head_valid  (bus.wr_valid),
        .head_pkt    (bus.wr_packet),
        .fifo_wait   (bus.emesh_rx_wr_wait),
        .overflow    (bus.wr_overflow)
    );

    erx_txn_fifo #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .WAIT_THRESH(WAIT_THRESH)
    ) u_rd_fifo (
        .rx_lclk_div4(rx_lclk_div4),
        .reset       (reset),
        .push        (rd_push),
        .pop         (bus.rd_ready),
        .push_pkt    (in_pkt),
        .head_valid  (bus.rd_valid),
        .head_pkt    (bus.rd_packet),
        .fifo_wait   (bus.emesh_rx_rd_wait),
        .overflow    (bus.rd_overflow)
    );

endmodule

// File: tb/tb_erx_txn_buffer.sv
// Scoreboard bench for erx_txn_buffer: a queue model per direction predicts
// heads, valid, wait and overflow after every clock.
module tb_erx_txn_buffer;
    import erx_pkg::*;

    localparam int DEPTH  = 16;
    localparam int THRESH = 10;

    logic rx_lclk_div4;
    logic reset;

    erx_txn_buffer_if bus();

    erx_txn_buffer #(.DEPTH(DEPTH), .AW(4), .WAIT_THRESH(THRESH)) dut (
        .rx_lclk_div4(rx_lclk_div4),
        .reset       (reset),
        .bus         (bus)
    );

    initial rx_lclk_div4 = 1'b0;
    always #5 rx_lclk_div4 = ~rx_lclk_div4;

    logic [RX_PKT_W-1:0] wq[$];
    logic [RX_PKT_W-1:0] rq[$];
    bit wovf_m, rovf_m;
    int n_vec, n_err;

    task automatic check_eq(input string tag, input logic [RX_PKT_W-1:0] obs,
                            input logic [RX_PKT_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check_eq("wr_valid", RX_PKT_W'(bus.wr_valid), RX_PKT_W'(wq.size() != 0));
        check_eq("rd_valid", RX_PKT_W'(bus.rd_valid), RX_PKT_W'(rq.size() != 0));
        check_eq("wr_wait", RX_PKT_W'(bus.emesh_rx_wr_wait), RX_PKT_W'(wq.size() >= THRESH));
        check_eq("rd_wait", RX_PKT_W'(bus.emesh_rx_rd_wait), RX_PKT_W'(rq.size() >= THRESH));
        check_eq("wr_ovf", RX_PKT_W'(bus.wr_overflow), RX_PKT_W'(wovf_m));
        check_eq("rd_ovf", RX_PKT_W'(bus.rd_overflow), RX_PKT_W'(rovf_m));
        if (wq.size() != 0) check_eq("wr_head", bus.wr_packet, wq[0]);
        if (rq.size() != 0) check_eq("rd_head", bus.rd_packet, rq[0]);
    endtask

    // Predict the edge from current inputs, clock it, update the model, check.
    task automatic step();
        bit wpop, rpop, wpush, rpush, wacc, racc;
        logic [RX_PKT_W-1:0] pkt;
        pkt   = {bus.in_datamode, bus.in_ctrlmode, bus.in_dstaddr, bus.in_srcaddr, bus.in_data};
        wpop  = bus.wr_ready && wq.size() != 0;
        rpop  = bus.rd_ready && rq.size() != 0;
        wpush = bus.in_access && bus.in_write;
        rpush = bus.in_access && !bus.in_write;
        wacc  = wpush && (wq.size() < DEPTH || wpop);
        racc  = rpush && (rq.size() < DEPTH || rpop);
        @(posedge rx_lclk_div4);
        @(negedge rx_lclk_div4);
        if (wpop) void'(wq.pop_front());
        if (rpop) void'(rq.pop_front());
        if (wacc) wq.push_back(pkt);
        if (racc) rq.push_back(pkt);
        if (wpush && !wacc) wovf_m = 1'b1;
        if (rpush && !racc) rovf_m = 1'b1;
        check_state();
    endtask

    task automatic set_txn(input bit wr);
        bus.in_access   = 1'b1;
        bus.in_write    = wr;
        bus.in_datamode = 2'($urandom);
        bus.in_ctrlmode = 4'($urandom);
        bus.in_dstaddr  = $urandom;
        bus.in_srcaddr  = $urandom;
        bus.in_data     = $urandom;
    endtask

    task automatic push_txn(input bit wr);
        set_txn(wr);
        step();
    endtask

    task automatic idle(input int n);
        bus.in_access = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        wovf_m = 1'b0;
        rovf_m = 1'b0;
        reset = 1'b1;
        bus.in_access = 1'b0;
        bus.in_write = 1'b0;
        bus.in_datamode = '0;
        bus.in_ctrlmode = '0;
        bus.in_dstaddr = '0;
        bus.in_srcaddr = '0;
        bus.in_data = '0;
        bus.wr_ready = 1'b0;
        bus.rd_ready = 1'b0;

        // Reset state
        @(negedge rx_lclk_div4);
        check_state();
        reset = 1'b0;

        // Single write with a known packet
        bus.in_access   = 1'b1;
        bus.in_write    = 1'b1;
        bus.in_datamode = 2'd2;
        bus.in_ctrlmode = 4'd5;
        bus.in_dstaddr  = 32'h8080_0000;
        bus.in_srcaddr  = 32'h0000_0abc;
        bus.in_data     = 32'h1234_5678;
        step();
        check_eq("single_valid", RX_PKT_W'(bus.wr_valid), RX_PKT_W'(1));
        check_eq("single_pkt", bus.wr_packet,
                 {2'd2, 4'd5, 32'h8080_0000, 32'h0000_0abc, 32'h1234_5678});
        check_eq("single_rd_valid", RX_PKT_W'(bus.rd_valid), RX_PKT_W'(0));
        idle(2);
        bus.wr_ready = 1'b1;
        idle(2);
        bus.wr_ready = 1'b0;

        // Fill reads to the wait threshold
        for (int i = 0; i < THRESH; i++) push_txn(1'b0);
        check_eq("rd_wait_at_10", RX_PKT_W'(bus.emesh_rx_rd_wait), RX_PKT_W'(1));
        check_eq("wr_wait_idle", RX_PKT_W'(bus.emesh_rx_wr_wait), RX_PKT_W'(0));

        // Up to full, then simultaneous push+pop while full
        for (int i = THRESH; i < DEPTH; i++) push_txn(1'b0);
        bus.rd_ready = 1'b1;
        push_txn(1'b0);
        bus.rd_ready = 1'b0;
        check_eq("full_pushpop_ovf", RX_PKT_W'(bus.rd_overflow), RX_PKT_W'(0));
        check_eq("full_pushpop_wait", RX_PKT_W'(bus.emesh_rx_rd_wait), RX_PKT_W'(1));

        // Push into full queue: dropped, sticky overflow
        push_txn(1'b0);
        check_eq("rd_ovf_set", RX_PKT_W'(bus.rd_overflow), RX_PKT_W'(1));
        idle(1);

        // Drain reads; model verifies order and that the dropped packet is absent
        bus.rd_ready = 1'b1;
        idle(DEPTH + 2);
        bus.rd_ready = 1'b0;
        check_eq("rd_drained", RX_PKT_W'(bus.rd_valid), RX_PKT_W'(0));
        check_eq("rd_ovf_sticky", RX_PKT_W'(bus.rd_overflow), RX_PKT_W'(1));

        // Wrap: 40 writes with randomly interleaved consumer ready
        for (int i = 0; i < 40; i++) begin
            bus.wr_ready = 1'($urandom_range(0, 1));
            push_txn(1'b1);
        end
        bus.wr_ready = 1'b1;
        idle(DEPTH + 2);
        bus.wr_ready = 1'b0;
        check_eq("wrap_drained", RX_PKT_W'(bus.wr_valid), RX_PKT_W'(0));

        // Reset mid-run with writes queued above threshold and rd overflow set
        for (int i = 0; i < 12; i++) push_txn(1'b1);
        bus.in_access = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_wr_valid", RX_PKT_W'(bus.wr_valid), RX_PKT_W'(0));
        check_eq("rst_wr_wait", RX_PKT_W'(bus.emesh_rx_wr_wait), RX_PKT_W'(0));
        check_eq("rst_rd_ovf", RX_PKT_W'(bus.rd_overflow), RX_PKT_W'(0));
        wq.delete();
        rq.delete();
        wovf_m = 1'b0;
        rovf_m = 1'b0;
        @(posedge rx_lclk_div4);
        @(negedge rx_lclk_div4);
        reset = 1'b0;
        check_state();
        push_txn(1'b1);
        check_eq("post_rst_valid", RX_PKT_W'(bus.wr_valid), RX_PKT_W'(1));
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
